// File: rtl/mips_multicycle_sequencer_if.sv
// Shared memory-port bundle between the multi-cycle sequencer and the memory.
// The sequencer is the master: it issues requests and the memory returns a one-cycle ack.
interface mips_multicycle_sequencer_if;
  logic mem_req;
  logic mem_we;
  logic mem_addr_sel;
  logic mem_ack;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr_sel,
    input  mem_ack
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr_sel,
    output mem_ack
  );
endinterface

// File: rtl/mips_multicycle_sequencer.sv
// Multi-cycle MIPS control sequencer: FETCH/DECODE/EXEC/MEM/WB stepping, memory-port
// arbitration, write-strobe timing, PC select resolution, timeout fault and retire count.
module mips_multicycle_sequencer #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  mips_multicycle_sequencer_if.master  mem,
  input  logic                         run,
  input  logic                         gp_we_dec,
  input  logic                         dm_we_dec,
  input  logic                         mem_op_dec,
  input  logic [1:0]                   pc_mux_dec,
  input  logic                         bce_true,
  output logic                         ir_we,
  output logic                         pc_we,
  output logic [1:0]                   pc_sel,
  output logic                         gp_we,
  output logic [2:0]                   state,
  output logic                         fault,
  output logic [CNT_W-1:0]             retired
);

  localparam logic [2:0] S_IDLE   = 3'b000;
  localparam logic [2:0] S_FETCH  = 3'b001;
  localparam logic [2:0] S_DECODE = 3'b010;
  localparam logic [2:0] S_EXEC   = 3'b011;
  localparam logic [2:0] S_MEM    = 3'b100;
  localparam logic [2:0] S_WB     = 3'b101;
  localparam logic [2:0] S_FAULT  = 3'b111;

  localparam int              WAIT_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
  localparam bit              TIMEOUT_EN = (TIMEOUT != 0);

  logic [2:0]        state_r;
  logic [2:0]        state_nxt_s;
  logic [WAIT_W-1:0] wait_cnt_r;
  logic              fault_r;
  logic [CNT_W-1:0]  retired_r;
  logic              mem_req_s;
  logic              ack_s;
  logic              expired_s;
  logic [1:0]        pc_sel_s;

  // The memory port is busy only in FETCH and MEM; an ack outside those states is ignored.
  assign mem_req_s = (state_r == S_FETCH) || (state_r == S_MEM);
  assign ack_s     = mem_req_s && mem.mem_ack;
  assign expired_s = TIMEOUT_EN && mem_req_s && !mem.mem_ack && (wait_cnt_r == WAIT_LAST);

  // Next-state logic; an ack in the expiry cycle takes priority over the fault.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (run) state_nxt_s = S_FETCH;
        else     state_nxt_s = S_IDLE;
      end
      S_FETCH: begin
        if (ack_s)          state_nxt_s = S_DECODE;
        else if (expired_s) state_nxt_s = S_FAULT;
        else                state_nxt_s = S_FETCH;
      end
      S_DECODE: state_nxt_s = S_EXEC;
      S_EXEC: begin
        if (mem_op_dec) state_nxt_s = S_MEM;
        else            state_nxt_s = S_WB;
      end
      S_MEM: begin
        if (ack_s)          state_nxt_s = S_WB;
        else if (expired_s) state_nxt_s = S_FAULT;
        else                state_nxt_s = S_MEM;
      end
      S_WB: begin
        if (run) state_nxt_s = S_FETCH;
        else     state_nxt_s = S_IDLE;
      end
      S_FAULT: state_nxt_s = S_FAULT;
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // PC select resolution: a not-taken branch falls back to PC+4.
  always_comb begin
    pc_sel_s = 2'b11;
    if ((state_r == S_EXEC) || (state_r == S_MEM) || (state_r == S_WB)) begin
      if ((pc_mux_dec == 2'b01) && !bce_true) pc_sel_s = 2'b11;
      else                                    pc_sel_s = pc_mux_dec;
    end else begin
      pc_sel_s = 2'b11;
    end
  end

  assign mem.mem_req      = mem_req_s;
  assign mem.mem_addr_sel = (state_r == S_MEM);
  assign mem.mem_we       = (state_r == S_MEM) && dm_we_dec;
  assign ir_we            = (state_r == S_FETCH) && mem.mem_ack;
  assign pc_we            = (state_r == S_WB);
  assign gp_we            = (state_r == S_WB) && gp_we_dec;
  assign pc_sel           = pc_sel_s;
  assign state            = state_r;
  assign fault            = fault_r;
  assign retired          = retired_r;

  // State register, wait counter, sticky fault and retire counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= S_IDLE;
      wait_cnt_r <= '0;
      fault_r    <= 1'b0;
      retired_r  <= '0;
    end else begin
      state_r <= state_nxt_s;
      // Counter idles at zero outside a pending request, so each FETCH/MEM entry starts clean.
      if (mem_req_s && !mem.mem_ack) wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
      else                           wait_cnt_r <= '0;
      if (state_nxt_s == S_FAULT) fault_r <= 1'b1;
      else                        fault_r <= fault_r;
      if (state_r == S_WB) retired_r <= retired_r + CNT_W'(1);
      else                 retired_r <= retired_r;
    end
  end

endmodule
